// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared types and constants for the SPI memory slave
// Purpose: FSM state encoding, latched frame kind, 2-bit command codes and
//          the frame-width derivation used by spi_mem_slave and its bench.
// Ports:   none (package)
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHK_CMD  = 3'd1,
    ST_RX_SHIFT = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_TX_SHIFT = 3'd4,
    ST_HOLD     = 3'd5
  } state_t;

  // Classification of the frame currently being received.
  typedef enum logic [1:0] {
    KIND_WRITE     = 2'd0,
    KIND_READ_ADD  = 2'd1,
    KIND_READ_DATA = 2'd2
  } kind_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Frame word = 2 command bits + address/data field.
  function automatic int frame_w(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/spi_shift_out.sv
// rtl/spi_shift_out.sv - parallel-load MSB-first serializer for MISO
// Purpose: holds the RAM read word and presents one bit per shift cycle.
// Ports:   clk, rst_n     - clock, synchronous active-low reset
//          i_clear        - zero the shift register and output bit
//          i_load/i_data  - parallel load of the word to send
//          i_shift        - drive next MSB on o_bit and shift left
//          o_bit          - registered serial output, 0 when not shifting
module spi_shift_out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_bit
);

  logic [DATA_W-1:0] r_shreg;
  logic              r_bit;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_shreg <= '0;
      r_bit   <= 1'b0;
    end else begin
      // The line idles low between shift cycles, so any non-shift cycle
      // (wait, hold, post-last-bit) drives 0.
      r_bit <= i_shift ? r_shreg[DATA_W-1] : 1'b0;
      if (i_load) begin
        r_shreg <= i_data;
      end else if (i_shift) begin
        r_shreg <= r_shreg << 1;
      end
    end
  end

  assign o_bit = r_bit;

endmodule

// File: rtl/spi_mem_slave.sv
// rtl/spi_mem_slave.sv - SPI slave front end for the single-port RAM
// Purpose: receives {cmd[1:0], field} frames on MOSI, hands them to the RAM
//          via rx_data/rx_valid, and serializes RAM read data onto MISO.
// Ports:   clk, rst_n  - system clock, synchronous active-low reset
//          SS_n, MOSI  - SPI select (frame = low period) and serial input
//          tx_valid, tx_data - RAM read data handshake
//          rx_data, rx_valid - received frame word and its one-cycle strobe
//          MISO        - serial read data output
//          frame_err   - one-cycle pulse when SS_n rises mid-frame
//          busy        - FSM not idle
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              frame_err,
  output logic              busy
);

  localparam int W  = frame_w(ADDR_W);
  localparam int CW = $clog2(W + DATA_W + 1);
  localparam logic [CW-1:0] CNT_RX_DONE = CW'(W);
  localparam logic [CW-1:0] CNT_TX_DONE = CW'(DATA_W);

  state_t         r_state;
  kind_t          r_kind;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_rx_shift;
  logic [W-1:0]   r_rx_data;
  logic           r_rx_valid;
  logic           r_frame_err;
  logic           r_read_pending;

  state_t         w_state_nxt;
  logic           w_frame_err;
  logic           w_shift_in;
  logic           w_latch_kind;
  logic           w_rx_done;
  logic           w_set_rp;
  logic           w_clr_rp;
  logic           w_cnt_inc;
  logic           w_cnt_clr;
  logic           w_tx_load;
  logic           w_tx_shift;
  logic           w_to_idle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_err  = 1'b0;
    w_shift_in   = 1'b0;
    w_latch_kind = 1'b0;
    w_rx_done    = 1'b0;
    w_set_rp     = 1'b0;
    w_clr_rp     = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_tx_load    = 1'b0;
    w_tx_shift   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!SS_n) w_state_nxt = ST_CHK_CMD;
      end
      ST_CHK_CMD: begin
        if (SS_n) begin
          w_frame_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_shift_in   = 1'b1;
          w_latch_kind = 1'b1;
          w_cnt_inc    = 1'b1;
          w_state_nxt  = ST_RX_SHIFT;
        end
      end
      ST_RX_SHIFT: begin
        // Word completion wins over a coincident SS_n rise: the word is
        // delivered without an error and the FSM simply returns to idle.
        if (r_cnt == CNT_RX_DONE) begin
          w_rx_done = 1'b1;
          w_cnt_clr = 1'b1;
          if (r_kind == KIND_READ_ADD) w_set_rp = 1'b1;
          if (SS_n) begin
            w_state_nxt = ST_IDLE;
          end else if (r_kind == KIND_READ_DATA) begin
            w_state_nxt = ST_TX_WAIT;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end else if (SS_n) begin
          w_frame_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_shift_in = 1'b1;
          w_cnt_inc  = 1'b1;
        end
      end
      ST_TX_WAIT: begin
        if (SS_n) begin
          w_frame_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (tx_valid) begin
          w_tx_load   = 1'b1;
          w_state_nxt = ST_TX_SHIFT;
        end
      end
      ST_TX_SHIFT: begin
        // read_pending is only cleared once the whole byte has gone out, so
        // an aborted data read can be retried.
        if (SS_n) begin
          w_frame_err = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_TX_DONE) begin
          w_clr_rp    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_tx_shift = 1'b1;
          w_cnt_inc  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (SS_n) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_to_idle = (w_state_nxt == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_rx_shift     <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_err    <= 1'b0;
      r_read_pending <= 1'b0;
      r_kind         <= KIND_WRITE;
    end else begin
      r_rx_valid  <= w_rx_done;
      r_frame_err <= w_frame_err;
      if (w_rx_done) r_rx_data <= r_rx_shift;
      if (w_to_idle) begin
        r_cnt      <= '0;
        r_rx_shift <= '0;
      end else begin
        if (w_cnt_clr) begin
          r_cnt <= '0;
        end else if (w_cnt_inc) begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_shift_in) r_rx_shift <= {r_rx_shift[W-2:0], MOSI};
      end
      if (w_latch_kind) begin
        if (MOSI == CMD_RD_ADDR[1]) begin
          r_kind <= r_read_pending ? KIND_READ_DATA : KIND_READ_ADD;
        end else begin
          r_kind <= KIND_WRITE;
        end
      end
      if (w_set_rp) begin
        r_read_pending <= 1'b1;
      end else if (w_clr_rp) begin
        r_read_pending <= 1'b0;
      end
    end
  end

  spi_shift_out #(
    .DATA_W (DATA_W)
  ) u_shift_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_to_idle),
    .i_load  (w_tx_load),
    .i_data  (tx_data),
    .i_shift (w_tx_shift),
    .o_bit   (MISO)
  );

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_mem_slave.sv
// tb/tb_spi_mem_slave.sv - self-checking bench for spi_mem_slave
module tb_spi_mem_slave;
  import spi_mem_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int W      = ADDR_W + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              SS_n;
  logic              MOSI;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic [W-1:0]      rx_data;
  logic              rx_valid;
  logic              MISO;
  logic              frame_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  bit m_rp   = 1'b0;   // reference model of the read-pending flag

  spi_mem_slave #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .MISO      (MISO),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI transaction driven from the model's point of view.
  // rx_abort: -1 none, n<W raise SS_n after n bits, W raise SS_n on completion edge.
  // tx_abort: -1 none, b raise SS_n (or reset if tx_rst) after b MISO bits
  //           (0 = together with tx_valid).
  task automatic run_frame(input logic [W-1:0] word, input int rx_abort,
                           input int tx_delay, input logic [DATA_W-1:0] txd,
                           input int tx_abort, input bit tx_rst);
    int kind;
    kind = (word[W-1] == 1'b0) ? 0 : (m_rp ? 2 : 1);
    SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'b0;
    step();
    chk("e0_busy", busy, 1);
    for (int n = 0; n < W; n++) begin
      if (rx_abort == n) begin
        SS_n = 1'b1;
        step();
        chk("rx_abort_err", frame_err, 1);
        chk("rx_abort_novalid", rx_valid, 0);
        step();
        chk("rx_abort_idle", busy, 0);
        chk("rx_abort_errpulse", frame_err, 0);
        return;
      end
      MOSI = word[W-1-n];
      tx_valid = 1'($urandom);   // must be ignored outside TX_WAIT
      tx_data = DATA_W'($urandom);
      step();
      chk("rx_novalid", rx_valid, 0);
      chk("rx_miso", MISO, 0);
      chk("rx_noerr", frame_err, 0);
    end
    tx_valid = 1'b0;
    if (rx_abort == W) SS_n = 1'b1;
    MOSI = 1'($urandom);
    step();
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, word);
    chk("rx_done_noerr", frame_err, 0);
    if (kind == 1) m_rp = 1'b1;
    if (rx_abort == W) begin
      step();
      chk("rx_edge_idle", busy, 0);
      chk("rx_edge_noerr", frame_err, 0);
      return;
    end
    if (kind == 2) begin
      for (int d = 0; d < tx_delay; d++) begin
        step();
        chk("txw_miso", MISO, 0);
        chk("txw_validpulse", rx_valid, 0);
      end
      tx_valid = 1'b1; tx_data = txd;
      if (tx_abort == 0) SS_n = 1'b1;
      step();
      tx_valid = 1'b0; tx_data = DATA_W'($urandom);
      if (tx_abort == 0) begin
        chk("txv_abort_err", frame_err, 1);
        chk("txv_abort_miso", MISO, 0);
        step();
        chk("txv_abort_idle", busy, 0);
        return;
      end
      for (int b = 0; b <= DATA_W; b++) begin
        if (b == tx_abort) begin
          if (tx_rst) begin
            rst_n = 1'b0;
            step();
            chk("rst_miso", MISO, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", frame_err, 0);
            chk("rst_rxv", rx_valid, 0);
            chk("rst_rxd", rx_data, 0);
            m_rp = 1'b0;
            rst_n = 1'b1; SS_n = 1'b1;
            step();
            chk("rst_idle", busy, 0);
          end else begin
            SS_n = 1'b1;
            step();
            chk("tx_abort_err", frame_err, 1);
            chk("tx_abort_miso", MISO, 0);
            step();
            chk("tx_abort_idle", busy, 0);
            chk("tx_abort_errpulse", frame_err, 0);
          end
          return;
        end
        step();
        if (b < DATA_W) begin
          chk("tx_bit", MISO, txd[DATA_W-1-b]);
        end else begin
          chk("tx_end_miso", MISO, 0);
          m_rp = 1'b0;
        end
      end
    end
    for (int h = 0; h < 2; h++) begin
      MOSI = 1'($urandom); tx_valid = 1'($urandom);
      step();
      chk("hold_miso", MISO, 0);
      chk("hold_busy", busy, 1);
      chk("hold_noerr", frame_err, 0);
    end
    tx_valid = 1'b0;
    SS_n = 1'b1;
    step();
    chk("end_noerr", frame_err, 0);
    chk("end_idle", busy, 0);
  endtask

  initial begin
    int rxa, txa;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    step(); step();
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_miso", MISO, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Write frame, then address read, then data read of 0xC3.
    run_frame({CMD_WR_ADDR, 8'hA5}, -1, 0, 8'h00, -1, 1'b0);
    run_frame({CMD_RD_ADDR, 8'h3C}, -1, 0, 8'h00, -1, 1'b0);
    run_frame({CMD_RD_DATA, 8'h00}, -1, 1, 8'hC3, -1, 1'b0);
    // Receive abort after 5 bits.
    run_frame({CMD_WR_DATA, 8'h5A}, 5, 0, 8'h00, -1, 1'b0);
    // Transmit abort after 3 bits, then retry.
    run_frame({CMD_RD_ADDR, 8'h11}, -1, 0, 8'h00, -1, 1'b0);
    run_frame({CMD_RD_DATA, 8'h22}, -1, 0, 8'h96, 3, 1'b0);
    run_frame({CMD_RD_DATA, 8'h22}, -1, 2, 8'h96, -1, 1'b0);
    // Reset during TX_SHIFT; following 1-led frame must be an address read.
    run_frame({CMD_RD_ADDR, 8'h33}, -1, 0, 8'h00, -1, 1'b0);
    run_frame({CMD_RD_DATA, 8'h44}, -1, 0, 8'hE7, 4, 1'b1);
    run_frame({CMD_RD_DATA, 8'h55}, -1, 0, 8'h00, -1, 1'b0);
    run_frame({CMD_RD_DATA, 8'h66}, -1, 0, 8'h81, -1, 1'b0);
    // SS_n rise coinciding with completion, then with tx_valid.
    run_frame({CMD_RD_ADDR, 8'h77}, W, 0, 8'h00, -1, 1'b0);
    run_frame({CMD_RD_DATA, 8'h88}, -1, 0, 8'hFF, 0, 1'b0);
    run_frame({CMD_RD_DATA, 8'h88}, -1, 3, 8'h5B, -1, 1'b0);
    // Abort on the post-last-bit edge keeps read pending.
    run_frame({CMD_RD_DATA, 8'h99}, -1, 0, 8'hA1, DATA_W, 1'b0);
    run_frame({CMD_RD_DATA, 8'h99}, -1, 0, 8'hA1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rxa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W)) : -1;
      txa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DATA_W)) : -1;
      run_frame(W'($urandom), rxa, int'($urandom_range(0, 3)),
                DATA_W'($urandom), txa, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
